alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Sequential, handshaked successor of the combinational ALU. Adds a valid/ready front/back end and status flags.
//  Keeps the same opcode map and adds arithmetic shift right. MUL/DIV run iteratively (shift-add / restoring),
//  so N can grow without a wide combinational multiplier or divider. Sits between operand registers and writeback.
// PARAMETERS
//  N   8   operand/result width in bits, N >= 2
//  CW  $clog2(N)+1   iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    reset, asynchronous assert, active-low
//  in_valid   in   1    operand/opcode bundle valid
//  in_ready   out  1    ALU can accept a bundle this cycle
//  a, b       in   N    operands
//  op         in   4    opcode (see BEHAVIOUR)
//  is_signed  in   1    1 = two's-complement interpretation
//  out_valid  out  1    result bundle valid
//  out_ready  in   1    consumer accepts result this cycle
//  result     out  N    main result (low product / quotient)
//  result_hi  out  N    MUL: high product half; DIV: remainder; else 0
//  flags      out  5    {div0, ovf, carry, neg, zero}
// BEHAVIOUR
//  Reset: async clear on rst_n=0. State=IDLE, in_ready=1, out_valid=0, result/result_hi/flags=0.
//   Any in-flight op is dropped. Nothing is produced after release.
//  Ops:
//   0000 ADD; 0001 SUB; 0010 MUL; 0011 DIV; 0100 AND; 0101 OR; 0110 NOT a;
//   0111 SLL; 1000 SRL; 1001 SRA (sign-fill).
//   Other codes: result=0, flags zero=1.
//  Shifts: amount = b as unsigned. Amount >= N gives 0 for SLL/SRL, and all-sign-bits for SRA.
//  State machine IDLE -> (BUSY) -> DONE:
//   IDLE: in_ready=1. On in_valid, latch a/b/op/is_signed.
//    Single-cycle ops go to DONE. MUL/DIV load the counter with N and go to BUSY.
//   BUSY: one iteration per clock; the counter decrements. When it reaches 0, go to DONE. in_ready=0.
//   DONE: out_valid=1, and outputs are held stable until out_ready=1.
//    in_ready = out_ready in DONE: accepting a new bundle on the same edge as the result transfer is legal (back-to-back).
//    out_ready=1 with no in_valid returns to IDLE.
//  Latency, from the accept edge to out_valid high:
//   single-cycle ops: 1 cycle, so back-to-back throughput is 1 op/cycle;
//   MUL/DIV: N+1 cycles.
//  Inputs are sampled only at acceptance; later changes to a/b/op are ignored.
//  Arithmetic:
//   ADD/SUB are N-bit wrap.
//    carry = carry-out (ADD) or NOT borrow (SUB).
//    ovf = signed overflow when is_signed=1, else 0.
//   MUL: 2N-bit product, signed when is_signed=1. result = low half, result_hi = high half.
//    ovf=1 if the product does not fit N bits in the selected signedness.
//   DIV: unsigned restoring on magnitudes.
//    Signed mode: truncate toward zero; remainder takes the sign of the dividend.
//    b==0: result=all ones, result_hi=a, div0=1, no hang (still N+1 cycles).
//    Signed MIN/-1: result=MIN, result_hi=0, ovf=1.
//  Flags:
//   zero = (result==0).
//   neg = result[N-1].
//   carry is 0 except ADD/SUB; ovf is 0 except ADD/SUB/MUL/DIV; div0 is 0 except DIV.
//   Flags are valid with out_valid.
//  Reset mid-BUSY or mid-DONE aborts with no output. The first op after reset behaves normally.
// TESTING
//  1. Reset, then ADD a=8'h7F b=8'h01 signed:
//     -> 1 cycle later out_valid, result=8'h80, ovf=1, neg=1, carry=0.
//  2. MUL a=8'hFF b=8'hFF, is_signed=0 then 1:
//     -> unsigned {hi,lo}=16'hFE01, ovf=1, out_valid at N+1=9 cycles;
//     -> signed {hi,lo}=16'h0001, ovf=0.
//  3. DIV a=-7 (8'hF9) b=2 signed:
//     -> result=8'hFD (-3), result_hi=8'hFF (-1).
//     Then DIV b=0 -> result=8'hFF, result_hi=a, div0=1.
//     Then 8'h80/8'hFF signed -> result=8'h80, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles after a SUB result:
//     -> result/flags stable, in_ready=0, no new accept.
//     Then raise out_ready with in_valid=1 -> transfer and accept on the same edge.
//  5. Stream of 4 ADDs with in_valid=out_ready=1 -> one result per cycle, in order, no bubbles.
//  6. Assert rst_n=0 at cycle 3 of a DIV:
//     -> out_valid=0 immediately (async), no stale output after release.
//     A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential, handshaked ALU with status flags.
//  Single-cycle ops (ADD/SUB/logic/shifts) finish one cycle after acceptance;
//  MUL (shift-add) and DIV (restoring) iterate N cycles on operand magnitudes.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  in_valid / in_ready   operand bundle handshake (a, b, op, is_signed)
//  out_valid / out_ready result handshake (result, result_hi, flags)
//  flags                 {div0, ovf, carry, neg, zero}
module alu_seq #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [4:0]   flags
);
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned NW = N + 1;
    localparam int unsigned PW = 2 * N;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   iter_op;

    // Latched operation context for MUL/DIV
    logic [CW-1:0] cnt_q;
    logic [3:0]    op_q;
    logic          sgn_q;
    logic          neg_q;      // final quotient/product must be negated
    logic          aneg_q;     // dividend negative: remainder negated
    logic [N-1:0]  a_q, b_q;
    logic [PW-1:0] mcand_q, prod_q;
    logic [N-1:0]  mplier_q;
    logic [N-1:0]  quo_q, rem_q, dvs_q;

    // Single-cycle datapath
    logic [NW-1:0] sum, dif;
    logic          shift_big;
    logic [N-1:0]  sc_res;
    logic          sc_carry, sc_ovf;

    // Magnitudes used by the iterative ops
    logic          a_sgn, b_sgn;
    logic [N-1:0]  a_mag, b_mag;

    // Iteration step and final fix-up
    logic [PW-1:0] prod_n, prod_s;
    logic [NW-1:0] r_sh;
    logic [N-1:0]  quo_n, rem_n, quo_s, rem_s;
    logic [N-1:0]  fin_res, fin_hi;
    logic          fin_ovf, fin_div0;

    // Output load path
    logic          ld_out;
    logic [N-1:0]  res_d, hi_d;
    logic          ovf_d, carry_d, div0_d;

    assign iter_op = (op == OP_MUL) || (op == OP_DIV);

    // Next state and handshake decode
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) state_d = iter_op ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = iter_op ? BUSY : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Single-cycle ops straight from the input bundle
    always_comb begin
        sc_res    = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        dif       = {1'b0, a} - {1'b0, b};
        shift_big = ({1'b0, b} >= NW'(N));
        case (op)
            OP_ADD: begin
                sc_res   = sum[N-1:0];
                sc_carry = sum[N];
                sc_ovf   = is_signed && (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_res   = dif[N-1:0];
                sc_carry = ~dif[N];
                sc_ovf   = is_signed && (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_NOT:  sc_res = ~a;
            OP_SLL:  sc_res = shift_big ? '0 : (a << b);
            OP_SRL:  sc_res = shift_big ? '0 : (a >> b);
            OP_SRA:  sc_res = shift_big ? {N{a[N-1]}} : N'($signed(a) >>> b);
            default: sc_res = '0;
        endcase
    end

    assign a_sgn = is_signed && a[N-1];
    assign b_sgn = is_signed && b[N-1];
    assign a_mag = a_sgn ? -a : a;
    assign b_mag = b_sgn ? -b : b;

    // One MUL/DIV iteration plus sign/exception fix-up of its outcome
    always_comb begin
        prod_n = prod_q + (mplier_q[0] ? mcand_q : '0);
        r_sh   = {rem_q, quo_q[N-1]};
        if (r_sh >= {1'b0, dvs_q}) begin
            rem_n = N'(r_sh - {1'b0, dvs_q});
            quo_n = {quo_q[N-2:0], 1'b1};
        end else begin
            rem_n = r_sh[N-1:0];
            quo_n = {quo_q[N-2:0], 1'b0};
        end
        prod_s   = neg_q  ? -prod_n : prod_n;
        quo_s    = neg_q  ? -quo_n  : quo_n;
        rem_s    = aneg_q ? -rem_n  : rem_n;
        fin_res  = '0;
        fin_hi   = '0;
        fin_ovf  = 1'b0;
        fin_div0 = 1'b0;
        if (op_q == OP_MUL) begin
            fin_res = prod_s[N-1:0];
            fin_hi  = prod_s[PW-1:N];
            fin_ovf = sgn_q ? (fin_hi != {N{fin_res[N-1]}}) : (fin_hi != '0);
        end else if (dvs_q == '0) begin
            fin_res  = '1;
            fin_hi   = a_q;
            fin_div0 = 1'b1;
        end else begin
            fin_res = quo_s;
            fin_hi  = rem_s;
            fin_ovf = sgn_q && (a_q == SMIN) && (b_q == '1);
        end
    end

    // Select what (if anything) lands in the output registers this cycle
    always_comb begin
        ld_out  = 1'b0;
        res_d   = '0;
        hi_d    = '0;
        ovf_d   = 1'b0;
        carry_d = 1'b0;
        div0_d  = 1'b0;
        if (accept && !iter_op) begin
            ld_out  = 1'b1;
            res_d   = sc_res;
            carry_d = sc_carry;
            ovf_d   = sc_ovf;
        end else if (state_q == BUSY && cnt_q == CW'(1)) begin
            ld_out = 1'b1;
            res_d  = fin_res;
            hi_d   = fin_hi;
            ovf_d  = fin_ovf;
            div0_d = fin_div0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            aneg_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            out_valid <= (state_d == DONE);
            if (accept && iter_op) begin
                cnt_q    <= CW'(N);
                op_q     <= op;
                sgn_q    <= is_signed;
                neg_q    <= a_sgn ^ b_sgn;
                aneg_q   <= a_sgn;
                a_q      <= a;
                b_q      <= b;
                mcand_q  <= PW'(a_mag);
                mplier_q <= b_mag;
                prod_q   <= '0;
                quo_q    <= a_mag;
                rem_q    <= '0;
                dvs_q    <= b_mag;
            end else if (state_q == BUSY) begin
                cnt_q    <= cnt_q - CW'(1);
                prod_q   <= prod_n;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                quo_q    <= quo_n;
                rem_q    <= rem_n;
            end
            if (ld_out) begin
                result    <= res_d;
                result_hi <= hi_d;
                flags     <= {div0_d, ovf_d, carry_d, res_d[N-1], (res_d == '0)};
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] op = 4'h0;
    logic       is_signed = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [4:0] flags;

    int checks = 0;
    int errors = 0;

    // Logic/shift/undefined-op vectors: op, a, b, expected result, expected flags
    logic [3:0] v_op  [0:10] = '{4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd9, 4'd4, 4'd5, 4'd6, 4'hC};
    logic [7:0] v_a   [0:10] = '{8'h81, 8'h81, 8'h80, 8'hFF, 8'h90, 8'h90, 8'h70, 8'hF0, 8'hF0, 8'h0F, 8'h55};
    logic [7:0] v_b   [0:10] = '{8'd1, 8'd8, 8'd7, 8'd200, 8'd2, 8'd9, 8'hFF, 8'h3C, 8'h0C, 8'h00, 8'h66};
    logic [7:0] v_res [0:10] = '{8'h02, 8'h00, 8'h01, 8'h00, 8'hE4, 8'hFF, 8'h00, 8'h30, 8'hFC, 8'hF0, 8'h00};
    logic [4:0] v_flg [0:10] = '{5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00010, 5'b00010,
                                 5'b00001, 5'b00000, 5'b00010, 5'b00010, 5'b00001};

    alu_seq #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Present a bundle and hold it until accepted; returns just after the accept edge
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic s);
        int n = 0;
        op = o; a = x; b = y; is_signed = s; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready stuck low op=%h", o);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; op = 4'hE; is_signed = ~s;
    endtask

    // Count cycles from the accept edge until out_valid (1 = visible right after accept)
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL wait_out_timeout: out_valid never rose");
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 8'h00)   begin errors++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if (result_hi !== 8'h00) begin errors++; $display("FAIL reset_result_hi: got %h want 00", result_hi); end
        checks++; if (flags !== 5'b0)     begin errors++; $display("FAIL reset_flags: got %b want 00000", flags); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_ovf();
        int cyc;
        issue(4'd0, 8'h7F, 8'h01, 1'b1);
        wait_out(cyc);
        checks++; if (cyc != 1)          begin errors++; $display("FAIL add_latency: got %0d want 1", cyc); end
        checks++; if (result !== 8'h80)  begin errors++; $display("FAIL add_result: got %h want 80", result); end
        checks++; if (flags !== 5'b01010) begin errors++; $display("FAIL add_flags: got %b want 01010", flags); end
        pop();
    endtask

    task automatic test_logic_shift();
        int cyc;
        for (int i = 0; i <= 10; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 1'b0);
            wait_out(cyc);
            checks++; if (result !== v_res[i]) begin errors++; $display("FAIL ls_result[%0d]: got %h want %h", i, result, v_res[i]); end
            checks++; if (flags !== v_flg[i])  begin errors++; $display("FAIL ls_flags[%0d]: got %b want %b", i, flags, v_flg[i]); end
            pop();
        end
    endtask

    task automatic test_mul();
        int cyc;
        issue(4'd2, 8'hFF, 8'hFF, 1'b0);
        wait_out(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL mulu_latency: got %0d want 9", cyc); end
        checks++; if ({result_hi, result} !== 16'hFE01) begin errors++; $display("FAIL mulu_product: got %h want FE01", {result_hi, result}); end
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL mulu_flags: got %b want 01000", flags); end
        pop();
        issue(4'd2, 8'hFF, 8'hFF, 1'b1);
        wait_out(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL muls_latency: got %0d want 9", cyc); end
        checks++; if ({result_hi, result} !== 16'h0001) begin errors++; $display("FAIL muls_product: got %h want 0001", {result_hi, result}); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL muls_flags: got %b want 00000", flags); end
        pop();
        issue(4'd2, 8'hF6, 8'h0C, 1'b1);  // -10 * 12 = -120 = 16'hFF88, fits signed 8 bits
        wait_out(cyc);
        checks++; if ({result_hi, result} !== 16'hFF88) begin errors++; $display("FAIL muls_neg_product: got %h want FF88", {result_hi, result}); end
        checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL muls_neg_flags: got %b want 00010", flags); end
        pop();
    endtask

    task automatic test_div();
        int cyc;
        issue(4'd3, 8'hF9, 8'h02, 1'b1);
        wait_out(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL div_latency: got %0d want 9", cyc); end
        checks++; if (result !== 8'hFD)    begin errors++; $display("FAIL div_quot: got %h want FD", result); end
        checks++; if (result_hi !== 8'hFF) begin errors++; $display("FAIL div_rem: got %h want FF", result_hi); end
        checks++; if (flags !== 5'b00010)  begin errors++; $display("FAIL div_flags: got %b want 00010", flags); end
        pop();
        issue(4'd3, 8'h35, 8'h00, 1'b1);
        wait_out(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL div0_latency: got %0d want 9", cyc); end
        checks++; if (result !== 8'hFF)    begin errors++; $display("FAIL div0_quot: got %h want FF", result); end
        checks++; if (result_hi !== 8'h35) begin errors++; $display("FAIL div0_rem: got %h want 35", result_hi); end
        checks++; if (flags !== 5'b10010)  begin errors++; $display("FAIL div0_flags: got %b want 10010", flags); end
        pop();
        issue(4'd3, 8'h80, 8'hFF, 1'b1);
        wait_out(cyc);
        checks++; if (result !== 8'h80)    begin errors++; $display("FAIL divmin_quot: got %h want 80", result); end
        checks++; if (result_hi !== 8'h00) begin errors++; $display("FAIL divmin_rem: got %h want 00", result_hi); end
        checks++; if (flags !== 5'b01010)  begin errors++; $display("FAIL divmin_flags: got %b want 01010", flags); end
        pop();
        issue(4'd3, 8'hC8, 8'h07, 1'b0);  // 200 / 7 = 28 rem 4
        wait_out(cyc);
        checks++; if ({result_hi, result} !== 16'h041C) begin errors++; $display("FAIL divu: got %h want 041C", {result_hi, result}); end
        pop();
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(4'd1, 8'h05, 8'h09, 1'b0);
        wait_out(cyc);
        op = 4'd0; a = 8'h01; b = 8'h01; is_signed = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 8'hFC || flags !== 5'b00010 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%h f=%b ir=%b want v=1 r=FC f=00010 ir=0",
                         i, out_valid, result, flags, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 8'h02) begin errors++; $display("FAIL bp_same_edge: got v=%b r=%h want v=1 r=02", out_valid, result); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xa  [0:3] = '{8'd1, 8'd10, 8'hFF, 8'h40};
        logic [7:0] xb  [0:3] = '{8'd2, 8'd20, 8'h01, 8'h40};
        logic [7:0] xr  [0:3] = '{8'd3, 8'd30, 8'h00, 8'h80};
        logic [4:0] xf  [0:3] = '{5'b00000, 5'b00000, 5'b00101, 5'b00010};
        out_ready = 1'b1;
        is_signed = 1'b0;
        op = 4'd0;
        for (int i = 0; i < 4; i++) begin
            a = xa[i]; b = xb[i]; in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== xr[i] || flags !== xf[i]) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got v=%b r=%h f=%b want v=1 r=%h f=%b", i, out_valid, result, flags, xr[i], xf[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_div();
        int  cyc;
        logic seen = 1'b0;
        issue(4'd3, 8'h64, 8'h07, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_async: got v=%b ir=%b want v=0 ir=1", out_valid, in_ready); end
        checks++; if (result !== 8'h00 || flags !== 5'b0) begin errors++; $display("FAIL rst_mid_clear: got r=%h f=%b want r=00 f=00000", result, flags); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_mid_stale: got out_valid=1 want 0"); end
        issue(4'd0, 8'd2, 8'd3, 1'b0);
        wait_out(cyc);
        checks++; if (cyc != 1 || result !== 8'd5) begin errors++; $display("FAIL rst_mid_next: got cyc=%0d r=%h want cyc=1 r=05", cyc, result); end
        pop();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_logic_shift();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
